// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the ioctl download/upload paths.
package ioctl_pkg;

  localparam int IOCTL_AW = 25;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LATCH} upl_state_t;

  // Byte k of a word, counted from the most significant lane.
  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] k,
                                          input int dw);
    logic [31:0] s;
    s = word >> (dw - 8 - 8 * int'(k));
    return s[7:0];
  endfunction

endpackage

// File: rtl/ioctl_upload_reader_byte_lane_mux.sv
// Selects one byte lane of a RAM word and registers it as the host-facing data byte.
module byte_lane_mux
  import ioctl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          load,
  input  logic          force_ff,
  input  logic [DW-1:0] word,
  input  logic [1:0]    lane,
  output logic [7:0]    dout
);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dout <= 8'hFF;
    end else if (load) begin
      dout <= force_ff ? 8'hFF : lane_sel(32'(word), lane, DW);
    end
  end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Byte-wide readback of a dual-port RAM over the ioctl upload channel.
// Define UPLOAD_CACHE_EN to keep the last word read so sequential bytes avoid RAM accesses.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int                  DW     = 16,
  parameter int                  AW     = 11,
  parameter logic [IOCTL_AW-1:0] BASE   = '0,
  parameter int                  RD_LAT = 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_rd,
  input  logic [DW-1:0]       ram_q,
  output logic                busy
);

  localparam int NB       = DW / 8;
  localparam int LG       = $clog2(NB);
  localparam int RAM_LAT  = RD_LAT - 1;  // cycles spent in WAIT

  upl_state_t          state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic [IOCTL_AW-1:0] off, idx_full;
  logic [1:0]          lane_req, lane_q;
  logic                oor, req, hit;
  logic                mux_load, mux_ff, mux_src_ram;
  logic [DW-1:0]       mux_word;
  logic [1:0]          mux_lane;

  always_comb begin
    off      = ioctl_addr - BASE;
    idx_full = off >> LG;
    oor      = (ioctl_addr < BASE) || ((idx_full >> AW) != '0);
    lane_req = 2'(off & IOCTL_AW'(NB - 1));
    req      = ioctl_rd && ioctl_upload && (state == IDLE);
  end

`ifdef UPLOAD_CACHE_EN
  logic [DW-1:0] word_q;
  logic [AW-1:0] tag;
  logic          tag_v;
  logic          upload_q;

  assign hit      = tag_v && (tag == AW'(idx_full)) && !oor;
  assign mux_word = mux_src_ram ? ram_q : word_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      tag      <= '0;
      tag_v    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      // Any cycle without an active session, or the first cycle of a new one, drops the tag.
      if (!ioctl_upload || !upload_q) begin
        tag_v <= 1'b0;
      end else if (mux_load && mux_src_ram) begin
        word_q <= ram_q;
        tag    <= ram_addr;
        tag_v  <= 1'b1;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign mux_word = ram_q;
`endif

  assign mux_lane = mux_src_ram ? lane_q : lane_req;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mux_load    = 1'b0;
    mux_ff      = 1'b0;
    mux_src_ram = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (oor) begin
            mux_load = 1'b1;
            mux_ff   = 1'b1;
          end else if (hit) begin
            mux_load = 1'b1;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (RAM_LAT == 0) begin
          state_n = LATCH;
        end else begin
          state_n = WAIT;
          cnt_n   = 2'(RAM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_n = LATCH;
        else             cnt_n   = cnt - 2'd1;
      end
      LATCH: begin
        mux_load    = 1'b1;
        mux_src_ram = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Session abort wins over everything; the data byte keeps its last value.
    if (!ioctl_upload) begin
      state_n  = IDLE;
      mux_load = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      lane_q     <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ram_rd     <= (state_n == ISSUE);
      ioctl_wait <= (state_n != IDLE);
      if (state == IDLE && state_n == ISSUE) begin
        ram_addr <= AW'(idx_full);
        lane_q   <= lane_req;
      end
    end
  end

  byte_lane_mux #(.DW(DW)) u_lane (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (mux_load),
    .force_ff(mux_ff),
    .word    (mux_word),
    .lane    (mux_lane),
    .dout    (ioctl_din)
  );

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Scoreboard bench: instance 0 is DW=16/BASE=0x100/RD_LAT=1, instance 1 is DW=32/BASE=0/RD_LAT=2.
module tb_ioctl_upload_reader;

`ifdef UPLOAD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT_A = CACHE ? 1 : 3;
  localparam int HIT_B = CACHE ? 1 : 4;
  localparam int HIT_P = CACHE ? 0 : 1;

  typedef struct {
    logic [7:0] b;
    int         lat;
    int         pulses;
  } exp_t;

  logic              clk_sys = 1'b0;
  logic [1:0]        rst, upl, rd, busy, wt, rrd;
  logic [1:0][24:0]  addr;
  logic [1:0][7:0]   din;
  logic [1:0][10:0]  raddr;
  logic [15:0]       q_a;
  logic [31:0]       q_b, q_b1;
  logic [15:0]       mem_a [0:2047];
  logic [31:0]       mem_b [0:2047];

  exp_t sb0[$];
  exp_t sb1[$];
  int   total = 0;
  int   bad   = 0;
  int   pend[2], cyc[2], pulses[2], waitc[2], rdcnt[2];

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_reader #(.DW(16), .AW(11), .BASE(25'h100), .RD_LAT(1)) dut_a (
    .clk_sys(clk_sys), .reset(rst[0]), .ioctl_upload(upl[0]), .ioctl_rd(rd[0]),
    .ioctl_addr(addr[0]), .ioctl_din(din[0]), .ioctl_wait(wt[0]), .ram_addr(raddr[0]),
    .ram_rd(rrd[0]), .ram_q(q_a), .busy(busy[0]));

  ioctl_upload_reader #(.DW(32), .AW(11), .BASE(25'h0), .RD_LAT(2)) dut_b (
    .clk_sys(clk_sys), .reset(rst[1]), .ioctl_upload(upl[1]), .ioctl_rd(rd[1]),
    .ioctl_addr(addr[1]), .ioctl_din(din[1]), .ioctl_wait(wt[1]), .ram_addr(raddr[1]),
    .ram_rd(rrd[1]), .ram_q(q_b), .busy(busy[1]));

  // RAM models return junk unless a read was issued at exactly the right latency.
  always @(posedge clk_sys) begin
    q_a  <= rrd[0] ? mem_a[raddr[0]] : 16'hDEAD;
    q_b1 <= rrd[1] ? mem_b[raddr[1]] : 32'hDEADBEEF;
    q_b  <= q_b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: tracks each accepted strobe until busy drops, then scores it.
  always @(negedge clk_sys) begin
    for (int i = 0; i < 2; i++) begin
      if (rrd[i]) rdcnt[i]++;
      if (rst[i]) begin
        pend[i] = 0;
      end else if (pend[i] != 0) begin
        cyc[i]++;
        if (rrd[i]) pulses[i]++;
        if (!busy[i]) begin
          exp_t e;
          pend[i] = 0;
          if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk("unexpected_response", 32'(i), 32'hFFFF);
          end else begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("din%0d", i), 32'(din[i]), 32'(e.b));
            chk($sformatf("latency%0d", i), 32'(cyc[i]), 32'(e.lat));
            chk($sformatf("ram_rd_pulses%0d", i), 32'(pulses[i]), 32'(e.pulses));
            chk($sformatf("wait_cycles%0d", i), 32'(waitc[i]), 32'(e.lat - 1));
            chk($sformatf("wait_low%0d", i), 32'(wt[i]), 32'd0);
          end
        end else begin
          if (wt[i]) waitc[i]++;
          if (cyc[i] > 40) begin
            chk($sformatf("timeout%0d", i), 32'(cyc[i]), 32'd0);
            pend[i] = 0;
          end
        end
      end else if (rd[i] && upl[i] && !busy[i]) begin
        pend[i]   = 1;
        cyc[i]    = 0;
        pulses[i] = 0;
        waitc[i]  = 0;
      end
    end
  end

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic push(input int i, input logic [7:0] b, input int lat, input int p);
    exp_t e;
    e.b = b; e.lat = lat; e.pulses = p;
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (sb_size(i) > 0 && n < 60) begin
      @(posedge clk_sys);
      n++;
    end
    if (sb_size(i) > 0) chk("drain", 32'(sb_size(i)), 32'd0);
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic rd_req(input int i, input logic [24:0] a, input logic [7:0] b,
                        input int lat, input int p);
    push(i, b, lat, p);
    @(posedge clk_sys); #1;
    rd[i] = 1'b1; addr[i] = a;
    @(posedge clk_sys); #1;
    rd[i] = 1'b0;
    drain(i);
  endtask

  initial begin
    int snap;
    for (int k = 0; k < 2048; k++) begin
      mem_a[k] = 16'h0;
      mem_b[k] = 32'h0;
    end
    mem_a[0] = 16'hA55A; mem_a[5] = 16'h1234; mem_a[2047] = 16'hC3D2;
    mem_b[0] = 32'hCAFEF00D; mem_b[1] = 32'h55667788; mem_b[3] = 32'h11223344;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; cyc[i] = 0; pulses[i] = 0; waitc[i] = 0; rdcnt[i] = 0;
    end
    rst = 2'b11; upl = 2'b00; rd = 2'b00; addr = '0;
    #23;
    for (int i = 0; i < 2; i++) begin
      chk("rst_din", 32'(din[i]), 32'hFF);
      chk("rst_wait", 32'(wt[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_ram_rd", 32'(rrd[i]), 32'd0);
      chk("rst_ram_addr", 32'(raddr[i]), 32'd0);
    end
    @(posedge clk_sys); #1;
    rst = 2'b00;
    @(posedge clk_sys); #1;
    upl = 2'b11;
    repeat (2) @(posedge clk_sys);

    // Instance 0: DW=16, BASE=0x100, RD_LAT=1
    rd_req(0, 25'h100,  8'hA5, 3, 1);
    rd_req(0, 25'h101,  8'h5A, HIT_A, HIT_P);
    rd_req(0, 25'h0FF,  8'hFF, 1, 0);
    rd_req(0, 25'h10FF, 8'hD2, 3, 1);
    rd_req(0, 25'h1100, 8'hFF, 1, 0);
    rd_req(0, 25'h10FE, 8'hC3, HIT_A, HIT_P);
    rd_req(0, 25'h10A,  8'h12, 3, 1);

    // Back-to-back strobe while busy is ignored
    push(0, 8'hA5, 3, 1);
    @(posedge clk_sys); #1; rd[0] = 1'b1; addr[0] = 25'h100;
    @(posedge clk_sys); #1; addr[0] = 25'h10B;
    @(posedge clk_sys); #1; rd[0] = 1'b0;
    drain(0);
    rd_req(0, 25'h10B, 8'h34, 3, 1);

    // Instance 1: DW=32, RD_LAT=2, sequential bytes of word 3
    rd_req(1, 25'd12, 8'h11, 4, 1);
    rd_req(1, 25'd13, 8'h22, HIT_B, HIT_P);
    rd_req(1, 25'd14, 8'h33, HIT_B, HIT_P);
    rd_req(1, 25'd15, 8'h44, HIT_B, HIT_P);

    // Upload dropped in WAIT: back to IDLE next cycle, data byte held
    push(1, 8'h44, 3, 1);
    @(posedge clk_sys); #1; rd[1] = 1'b1; addr[1] = 25'd0;
    @(posedge clk_sys); #1; rd[1] = 1'b0;
    @(posedge clk_sys); #1; upl[1] = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1; upl[1] = 1'b1;
    drain(1);
    rd_req(1, 25'd12, 8'h11, 4, 1);

    // Asynchronous reset in WAIT
    @(posedge clk_sys); #1; rd[1] = 1'b1; addr[1] = 25'd4;
    @(posedge clk_sys); #1; rd[1] = 1'b0;
    @(posedge clk_sys); #3; rst[1] = 1'b1;
    #1;
    chk("arst_din", 32'(din[1]), 32'hFF);
    chk("arst_wait", 32'(wt[1]), 32'd0);
    chk("arst_busy", 32'(busy[1]), 32'd0);
    chk("arst_ram_rd", 32'(rrd[1]), 32'd0);
    chk("arst_ram_addr", 32'(raddr[1]), 32'd0);
    @(posedge clk_sys); #1; rst[1] = 1'b0;
    snap = rdcnt[1];
    repeat (6) @(posedge clk_sys);
    #1;
    chk("post_rst_din", 32'(din[1]), 32'hFF);
    chk("post_rst_ram_rd", 32'(rdcnt[1] - snap), 32'd0);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);
    rd_req(1, 25'd13, 8'h22, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ioctl_upload_reader.md
# ioctl_upload_reader

Reads game-side dual-port RAM back out to the HPS over the ioctl upload channel, one byte per host read strobe. It is the inverse of the ROM/NVRAM download path: byte order within a RAM word matches the download accumulator, where the first byte lands in the most significant lane. It sits in `emu` beside the download write decoders, drives a dedicated read port of a `dpram` (or a mux in front of one), and feeds `ioctl_din` of `hps_io`.

## Interface
- `DW`, default 16: RAM word width. Legal values are 8, 16, 32. NB = DW/8 bytes per word.
- `AW`, default 11: RAM word-address width.
- `BASE`, default 0: byte offset subtracted from `ioctl_addr` before decoding.
- `RD_LAT`, default 1: RAM read latency in cycles, from `ram_rd` to `ram_q` valid. Legal range 1..3.

Ports:
- `clk_sys` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_upload` in 1: upload session active.
- `ioctl_rd` in 1: one-cycle host read strobe.
- `ioctl_addr` in 25: byte address of the request.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: host must not sample `ioctl_din` or issue a new strobe while this is high.
- `ram_addr` out AW: RAM word address.
- `ram_rd` out 1: one-cycle read request.
- `ram_q` in DW: RAM read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Offset: `off = ioctl_addr - BASE`, 25-bit unsigned.
- Word index: `off >> log2(NB)`.
- Lane: `k = off mod NB`. The returned byte is `ram_q[DW-1-8k -: 8]`.
- Range check: if `ioctl_addr < BASE` or the word index is ≥ 2^AW, the request is out of range. It returns 8'hFF, makes no RAM access, and does not raise `ioctl_wait`.
- FSM states:
  - IDLE: `ioctl_rd & ioctl_upload` → ISSUE on a miss; a hit or out-of-range request is served directly from IDLE.
  - ISSUE: `ram_rd`=1 and `ram_addr` driven. Go to WAIT with `cnt` = RAM_LAT − 1.
  - WAIT: decrement `cnt`; at 0 go to LATCH.
  - LATCH: capture `ram_q` into `word_q`, record the tag, drive `ioctl_din`, drop `ioctl_wait`, go to IDLE.
- `ioctl_rd` arriving in any state other than IDLE is ignored; this is a host protocol violation. `ioctl_din` and `ioctl_wait` are not disturbed.
- Upload abort: `ioctl_upload` low in any state forces IDLE next cycle, sets `ioctl_wait`=0, and invalidates the cache. `ioctl_din` holds its value.
- A rising edge of `ioctl_upload` invalidates the cache.
- `ram_addr` holds its last value outside ISSUE.

## Timing
- Reset values: `ioctl_din`=8'hFF, `ioctl_wait`=0, `ram_addr`=0, `ram_rd`=0, `busy`=0, state IDLE, cache invalid.
- Strobe sampled at cycle 0.
- Miss:
  - Cycle 1: ISSUE, `ram_rd`=1, `ioctl_wait`=1.
  - `ram_q` is sampled at cycle 1+RD_LAT.
  - `ioctl_din` valid and `ioctl_wait`=0 at cycle 2+RD_LAT. With RD_LAT=1 this is cycle 3.
- Hit or out-of-range: `ioctl_din` valid at cycle 1, `ioctl_wait` stays 0.
- `ioctl_wait` is a registered output. The host samples it from cycle 1 on.
- A new strobe is accepted from the first cycle in which `busy`=0.

## Configuration
- `UPLOAD_CACHE_EN` defined:
  - A one-word cache holds `word_q` plus a tag (word index and a valid bit).
  - A request whose word index equals the valid tag is a hit and is served from `word_q` with no RAM access.
  - Sequential reads therefore touch RAM once per NB bytes.
- Undefined:
  - Every in-range request is a miss and goes through ISSUE/WAIT/LATCH.
  - No tag register exists.

## Structure
- Package `ioctl_pkg`:
  - state enum `upl_state_t` {IDLE, ISSUE, WAIT, LATCH};
  - function `lane_sel(word, k, DW)`;
  - constant `IOCTL_AW = 25`.
- The same package is used by the download decoders.
- Sub-module `byte_lane_mux`: combinational DW→8 lane select with registered output.
- The FSM, range check and cache stay in the top module.

## Test plan
- DW=16, RD_LAT=1, BASE=0, RAM word 0 = 16'hA55A. Strobe addr 0 → `ioctl_wait` high cycles 1–2, `ioctl_din`=8'hA5 at cycle 3. Strobe addr 1 → 8'h5A.
  - With `UPLOAD_CACHE_EN`: the second read completes at cycle 1 with zero `ram_rd` pulses.
  - Without it: the second read takes 3 cycles.
- DW=32, RAM word 3 = 32'h11223344. Strobe bytes 12..15 in order → 8'h11, 8'h22, 8'h33, 8'h44. With cache: exactly one `ram_rd` pulse.
- BASE=25'h100, AW=11, DW=16:
  - addr 25'h0FF → 8'hFF at cycle 1, no `ram_rd`.
  - addr 25'h100+4096 → 8'hFF, no `ram_rd`.
  - addr 25'h100+4095 → RAM word 2047, low lane.
- Strobe at cycle 0, second strobe at cycle 1 → second ignored. Exactly one `ram_rd`; `ioctl_din` reflects the first address.
- `ioctl_upload` dropped in WAIT → IDLE next cycle, `ioctl_wait`=0. A new session re-reads RAM: the cache is invalidated even for the same address.
- `reset` asserted asynchronously in WAIT → all outputs at reset values in the same cycle. No LATCH occurs after release.
